// File: rtl/jeff_mux_rr_reg_if.sv
// rtl/jeff_mux_rr_reg_if.sv - channel-side and output-side handshake bundle for jeff_mux_rr_reg
//
// Purpose: groups the per-channel inputs and the registered output of the mux.
// Ports (signals):
//   in_data  [CHANNELS*WIDTH] channel i at bits [i*WIDTH +: WIDTH]
//   in_valid [CHANNELS]       per-channel valid
//   in_ready [CHANNELS]       per-channel accept, one-hot or zero
//   y        [WIDTH]          registered output data
//   y_valid                   output register holds data
//   y_ready                   downstream accepts y
//   y_ch     [SEL_W]          source channel of y
// Modports: slave = the mux itself, master = producers plus consumer around it.
interface jeff_mux_rr_reg_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          y;
  logic                      y_valid;
  logic                      y_ready;
  logic [SEL_W-1:0]          y_ch;

  modport slave (
    input  in_data, in_valid, y_ready,
    output in_ready, y, y_valid, y_ch
  );

  modport master (
    output in_data, in_valid, y_ready,
    input  in_ready, y, y_valid, y_ch
  );
endinterface

// File: rtl/jeff_mux_rr_reg.sv
// rtl/jeff_mux_rr_reg.sv - N-channel registered mux with fixed or round-robin selection
//
// Purpose: picks one requesting channel per cycle (fixed select s, or
// round-robin after the last accepted channel) into a one-entry output
// register with valid/ready.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     0 blocks new acceptances (held word may still drain)
//   mode   0 = fixed select via s, 1 = round-robin
//   s      channel select for mode 0; values >= CHANNELS never grant
//   bus    jeff_mux_rr_reg_if.slave: in_data/in_valid/in_ready, y/y_valid/y_ready/y_ch
module jeff_mux_rr_reg #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] s,
  jeff_mux_rr_reg_if.slave bus
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_data;
  logic             out_free;
  logic             take;

  assign out_free = !bus.y_valid || bus.y_ready;

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      // Comparing against every legal index means s >= CHANNELS matches nothing.
      for (int i = 0; i < CHANNELS; i++) begin
        if (s == SEL_W'(i) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Walk from farthest to nearest so the nearest requester after rr_ptr wins.
      for (int off = CHANNELS; off >= 1; off--) begin
        idx = 32'(rr_ptr) + off;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (bus.in_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gates in_ready so nothing is offered while reset is held.
  assign bus.in_ready = (rst_n && en && out_free && grant_vld) ?
                        (CHANNELS'(1) << grant_idx) : '0;
  assign take = |(bus.in_valid & bus.in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
      bus.y_ch    <= '0;
      rr_ptr      <= SEL_W'(CHANNELS - 1);
    end else if (take) begin
      bus.y       <= grant_data;
      bus.y_ch    <= grant_idx;
      bus.y_valid <= 1'b1;
      rr_ptr      <= grant_idx;
    end else if (bus.y_valid && bus.y_ready) begin
      bus.y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jeff_mux_rr_reg.sv
// tb/tb_jeff_mux_rr_reg.sv - self-checking bench for jeff_mux_rr_reg
module tb_jeff_mux_rr_reg;

  logic       clk;
  logic       rst_n;
  logic       en, mode;
  logic [1:0] s;
  logic       en3, mode3;
  logic [1:0] s3;

  jeff_mux_rr_reg_if #(.WIDTH(4), .CHANNELS(4)) bus ();
  jeff_mux_rr_reg_if #(.WIDTH(4), .CHANNELS(3)) bus3 ();

  jeff_mux_rr_reg #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .bus(bus)
  );

  jeff_mux_rr_reg #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .s(s3), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         do_reset;
    bit         mode;
    logic [1:0] s;
    bit         en;
    logic [3:0] valid;
    bit         y_ready;
    logic [3:0] exp_rdy;
    bit         exp_yv;
  } vec_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] d;
  } sb_t;

  vec_t       vecs[$];
  sb_t        sb_q[$];
  logic [3:0] last_y;
  logic [1:0] last_ch;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void add(bit r, bit m, logic [1:0] sv, bit e, logic [3:0] v,
                              bit yr, logic [3:0] er, bit ev);
    vecs.push_back('{r, m, sv, e, v, yr, er, ev});
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mode = 1'b1; en = 1'b1; bus.in_valid = 4'b1111; bus.y_ready = 1'b1;
    #1;
    chk("reset y", bus.y, 4'h0);
    chk("reset y_valid", bus.y_valid, 1'b0);
    chk("reset y_ch", bus.y_ch, 2'd0);
    chk("reset in_ready", bus.in_ready, 4'b0000);
    @(negedge clk);
    bus.in_valid = 4'b0000;
    en = 1'b0;
    rst_n = 1'b1;
    sb_q.delete();
    last_y = 4'h0;
    last_ch = 2'd0;
  endtask

  task automatic step(input vec_t v, input int n);
    sb_t e;
    int  ch;
    if (v.do_reset) apply_reset();
    @(negedge clk);
    mode = v.mode; s = v.s; en = v.en;
    bus.in_valid = v.valid; bus.y_ready = v.y_ready;
    #1;
    chk($sformatf("row%0d in_ready", n), bus.in_ready, v.exp_rdy);
    if (v.exp_rdy != 4'b0000) begin
      ch = 0;
      for (int k = 0; k < 4; k++) if (v.exp_rdy[k]) ch = k;
      e.ch = ch[1:0];
      e.d  = bus.in_data[ch*4 +: 4];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk($sformatf("row%0d y_valid", n), bus.y_valid, v.exp_yv);
    if (v.exp_rdy != 4'b0000) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL row%0d scoreboard empty actual=0 required=1", n);
      end else begin
        e = sb_q.pop_front();
        last_y = e.d;
        last_ch = e.ch;
      end
    end
    chk($sformatf("row%0d y", n), bus.y, last_y);
    chk($sformatf("row%0d y_ch", n), bus.y_ch, last_ch);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; mode = 1'b0; s = 2'd0;
    bus.in_data = {4'h9, 4'h3, 4'h5, 4'ha};
    bus.in_valid = 4'b0000; bus.y_ready = 1'b1;
    en3 = 1'b1; mode3 = 1'b0; s3 = 2'd3;
    bus3.in_data = {4'h7, 4'h6, 4'h1};
    bus3.in_valid = 3'b111; bus3.y_ready = 1'b1;
    last_y = 4'h0; last_ch = 2'd0;

    // fixed select s=2, sustained; then s pointing at an idle channel
    add(1, 0, 2'd2, 1, 4'b1111, 1, 4'b0100, 1);
    add(0, 0, 2'd2, 1, 4'b1111, 1, 4'b0100, 1);
    add(0, 0, 2'd2, 1, 4'b1111, 1, 4'b0100, 1);
    add(0, 0, 2'd1, 1, 4'b1101, 1, 4'b0000, 0);
    // round-robin fairness from reset
    add(1, 1, 2'd0, 1, 4'b1111, 1, 4'b0001, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 1, 4'b0010, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 1, 4'b0100, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 1, 4'b1000, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 1, 4'b0001, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 1, 4'b0010, 1);
    // sparse requests with wrap
    add(0, 1, 2'd0, 1, 4'b1000, 1, 4'b1000, 1);
    add(0, 1, 2'd0, 1, 4'b1001, 1, 4'b0001, 1);
    add(0, 1, 2'd0, 1, 4'b1001, 1, 4'b1000, 1);
    add(0, 1, 2'd0, 1, 4'b1001, 1, 4'b0001, 1);
    // backpressure holding ch1, then release goes to ch2
    add(0, 1, 2'd0, 1, 4'b0010, 1, 4'b0010, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 0, 4'b0000, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 0, 4'b0000, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 0, 4'b0000, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 1, 4'b0100, 1);
    // enable low drains, pointer frozen at ch2 so ch3 is next
    add(0, 1, 2'd0, 0, 4'b1111, 1, 4'b0000, 0);
    add(0, 1, 2'd0, 0, 4'b1111, 1, 4'b0000, 0);
    add(0, 1, 2'd0, 1, 4'b1111, 1, 4'b1000, 1);
    add(0, 1, 2'd0, 1, 4'b0000, 1, 4'b0000, 0);
    // mode switch takes effect in the same cycle
    add(0, 0, 2'd1, 1, 4'b1111, 1, 4'b0010, 1);
    add(0, 1, 2'd0, 1, 4'b1111, 1, 4'b0100, 1);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);
    chk("scoreboard drained", sb_q.size(), 0);

    // async reset mid-stream while y holds ch3 data
    step('{1, 1, 2'd0, 1, 4'b1111, 1, 4'b0001, 1}, 100);
    step('{0, 1, 2'd0, 1, 4'b1111, 1, 4'b0010, 1}, 101);
    step('{0, 1, 2'd0, 1, 4'b1111, 1, 4'b0100, 1}, 102);
    step('{0, 1, 2'd0, 1, 4'b1111, 1, 4'b1000, 1}, 103);
    chk("pre-reset y", bus.y, 4'h9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async y", bus.y, 4'h0);
    chk("async y_valid", bus.y_valid, 1'b0);
    chk("async y_ch", bus.y_ch, 2'd0);
    chk("async in_ready", bus.in_ready, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", bus.in_ready, 4'b0001);
    @(posedge clk);
    #1;
    chk("post-reset y_valid", bus.y_valid, 1'b1);
    chk("post-reset y_ch", bus.y_ch, 2'd0);
    chk("post-reset y", bus.y, 4'ha);

    // three-channel build: s=3 never grants
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("ch3 s3 in_ready%0d", i), bus3.in_ready, 3'b000);
      chk($sformatf("ch3 s3 y_valid%0d", i), bus3.y_valid, 1'b0);
    end
    @(negedge clk);
    s3 = 2'd2;
    #1;
    chk("ch3 s2 in_ready", bus3.in_ready, 3'b100);
    @(posedge clk);
    #1;
    chk("ch3 s2 y", bus3.y, 4'h7);
    chk("ch3 s2 y_ch", bus3.y_ch, 2'd2);
    chk("ch3 s2 y_valid", bus3.y_valid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jeff_mux_rr_reg.md
Name: jeff_mux_rr_reg

Overview:
- Parametrised successor to the quad 2:1 mux family: an N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes.
- Two selection modes:
  - fixed select (74x157-style `s` input);
  - round-robin arbitration across all requesting channels.
- One-entry output register with valid/ready.
- Sits between multiple producers and a single downstream consumer.

Parameters:
- WIDTH, 4, data bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS), select/channel-ID width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  enable; 0 blocks new acceptances
- mode  input  1  0 = fixed select, 1 = round-robin
- s  input  SEL_W  channel select, used when mode=0
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- in_ready  output  CHANNELS  per-channel accept; one-hot or zero
- y  output  WIDTH  registered output data
- y_valid  output  1  output register holds data
- y_ready  input  1  downstream accepts y
- y_ch  output  SEL_W  source channel of current y

Behaviour:
- Reset (rst_n low, asynchronous):
  - y=0, y_valid=0, y_ch=0, rr_ptr=CHANNELS-1, so channel 0 has first priority.
  - in_ready=0 while reset is asserted.
  - Reset mid-transfer discards the held word; no partial state survives.
- Definitions:
  - out_free = !y_valid || y_ready.
  - Grant is computed combinationally each cycle.
- Grant, mode=0:
  - grant=s if s<CHANNELS and in_valid[s]; otherwise no grant.
  - s>=CHANNELS never grants; no error is flagged.
- Grant, mode=1:
  - Grant the first i with in_valid[i], searching from (rr_ptr+1) mod CHANNELS upward with wrap-around.
- in_ready[grant] = en && out_free && grant exists; all other bits are 0.
  - in_ready must not depend on in_valid of the granted channel beyond grant selection.
- Transfer occurs when in_valid[i] && in_ready[i]. On the next clock edge:
  - y=in_data slice i, y_ch=i, y_valid=1;
  - rr_ptr=i, in both modes.
  - Latency is 1 cycle from acceptance to y_valid.
- Output side:
  - y_valid && y_ready with no new transfer → y_valid=0 next cycle.
  - y and y_ch hold their last value, not cleared.
- Simultaneous consume and accept in the same cycle → y is replaced, y_valid stays 1, and full throughput of 1 word/cycle is sustained.
- Backpressure: y_valid && !y_ready → y, y_ch, y_valid are held stable and all in_ready=0.
- en=0:
  - No new acceptances.
  - Any held word remains valid and can still drain.
  - rr_ptr is frozen.
- Mode or s changes:
  - Take effect on the grant in the same cycle.
  - Never corrupt a held word.
- Fairness in mode=1: with all channels continuously valid and y_ready=1, grants cycle 0,1,…,CHANNELS-1,0,… with no repeats.

Test Plan:
1. Reset, then fixed mode:
   - Stimulus: mode=0, s=2, en=1, in_valid=4'b1111, in_data={4'h9,4'h3,4'h5,4'ha} (ch3..ch0), y_ready=1.
   - Required: in_ready=4'b0100; one cycle later y=4'h3, y_ch=2, y_valid=1, sustained every cycle.
2. Round-robin fairness:
   - Stimulus: mode=1, all valid, y_ready=1, from reset.
   - Required: y_ch sequence 0,1,2,3,0,1 on consecutive cycles with y=4'ha,4'h5,4'h3,4'h9,…
3. Sparse requests with wrap:
   - Stimulus: mode=1, in_valid=4'b1001 after a grant to ch3.
   - Required: next grant is ch0 (wrap-around), then ch3; channels 1 and 2 never granted.
4. Backpressure:
   - Stimulus: y_ready=0 for 3 cycles with the output holding ch1 data 4'h5.
   - Required: y=4'h5, y_ch=1, y_valid=1 stable; in_ready=0; rr_ptr unchanged.
   - On release: next grant is ch2.
5. Enable and invalid select:
   - Stimulus A: en=0 with y_valid=1, y_ready=1.
   - Required A: y_valid falls the next cycle; in_ready=0; no new data.
   - Stimulus B: mode=0, s=3, CHANNELS=3 build.
   - Required B: in_ready=0 permanently.
6. Async reset mid-stream:
   - Stimulus: drop rst_n between clock edges while y_valid=1 and y=4'h9.
   - Required: y=0, y_valid=0, y_ch=0, in_ready=0 immediately, without waiting for clk.
   - After release in mode=1: first grant is ch0.
